// File: rtl/matvec_col_mac.sv
// Purpose : column-wise matrix-vector MAC, y = sum_j x[j]*col_j over N columns of N signed elements.
// Latency : start edge S, columns accepted at S+1..S+N when unstalled, y_valid high after edge S+N+1.
// Backpr. : col_ready is high only while accumulating; col_valid low stalls indefinitely, no timeout.
// Ports   : clk/rst (sync, active-high); start+vec begin an operation (vec latched, element 0 in MSBs);
//           col_valid/col_ready/col_data stream the N columns; busy covers ACCUM and DRAIN;
//           y_valid pulses one cycle when y (N x ACCW, element 0 in MSBs) is updated; y holds otherwise.
module matvec_col_mac #(
    parameter int N    = 16,
    parameter int DW   = 16,
    parameter int ACCW = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*DW-1:0]   vec,
    input  logic              col_valid,
    input  logic [N*DW-1:0]   col_data,
    output logic              col_ready,
    output logic              busy,
    output logic              y_valid,
    output logic [N*ACCW-1:0] y
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                   accept;
    logic                   start_acc;
    logic                   prod_v;
    logic [CW-1:0]          col_cnt;

    logic signed [DW-1:0]   x      [N];
    logic signed [DW-1:0]   vec_e  [N];
    logic signed [DW-1:0]   col_e  [N];
    logic signed [DW-1:0]   x_sel;
    logic signed [ACCW-1:0] p_nxt  [N];
    logic signed [ACCW-1:0] p      [N];
    logic signed [ACCW-1:0] acc    [N];
    logic signed [ACCW-1:0] y_r    [N];

    // Unpack the flat buses: element 0 lives in the MSBs.
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign vec_e[g] = vec[(N-1-g)*DW +: DW];
        assign col_e[g] = col_data[(N-1-g)*DW +: DW];
        assign y[(N-1-g)*ACCW +: ACCW] = y_r[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_ready = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                // col_valid is deliberately ignored here, even alongside start.
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                col_ready = 1'b1;
                busy      = 1'b1;
                accept    = col_valid;
                if (col_valid && (col_cnt == CW'(N - 1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Weight for the column being accepted now.
    assign x_sel = x[col_cnt];

    // Full-precision signed product, then sign-extended (or wrapped) to ACCW.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            p_nxt[i] = ACCW'(PW'(col_e[i]) * PW'(x_sel));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            prod_v  <= 1'b0;
            y_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x[i]   <= '0;
                p[i]   <= '0;
                acc[i] <= '0;
                y_r[i] <= '0;
            end
        end else begin
            prod_v  <= accept;
            y_valid <= (state == DRAIN);

            // prod_v is never set in IDLE, so the clear on start cannot collide with an add.
            if (start_acc) begin
                col_cnt <= '0;
                for (int i = 0; i < N; i++) begin
                    x[i]   <= vec_e[i];
                    acc[i] <= '0;
                end
            end else if (prod_v) begin
                for (int i = 0; i < N; i++) begin
                    acc[i] <= acc[i] + p[i];
                end
            end

            if (accept) begin
                col_cnt <= col_cnt + 1'b1;
                for (int i = 0; i < N; i++) begin
                    p[i] <= p_nxt[i];
                end
            end

            // Last product is still in p; fold it in while writing the result.
            if (state == DRAIN) begin
                for (int i = 0; i < N; i++) begin
                    y_r[i] <= acc[i] + p[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_matvec_col_mac.sv
module tb_matvec_col_mac;

    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int ACCW = 36;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              col_valid = 1'b0;
    logic [N*DW-1:0]   vec = '0;
    logic [N*DW-1:0]   col_data = '0;
    logic              col_ready;
    logic              busy;
    logic              y_valid;
    logic [N*ACCW-1:0] y;

    matvec_col_mac #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec       (vec),
        .col_valid (col_valid),
        .col_data  (col_data),
        .col_ready (col_ready),
        .busy      (busy),
        .y_valid   (y_valid),
        .y         (y)
    );

    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;
    longint scyc   = 0;
    int     rdy_cnt = 0;
    int     pulses  = 0;
    logic   chk_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus matrix: mat[j][i] is element i of column j; tv is the vector x.
    logic signed [DW-1:0] mat [N][N];
    logic signed [DW-1:0] tv  [N];

    function automatic logic [N*DW-1:0] pack_col(input int j);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[(N-1-i)*DW +: DW] = mat[j][i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack_vec();
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[(N-1-i)*DW +: DW] = tv[i];
        return r;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmpv(input string nm, input logic [N*ACCW-1:0] act, input logic [N*ACCW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic longint y_elem(input int i);
        logic signed [ACCW-1:0] e;
        e = y[(N-1-i)*ACCW +: ACCW];
        return longint'(e);
    endfunction

    // Transaction-level model: phase 0 idle, 1 collecting columns, 2 result pending.
    int                ph = 0;
    int                mcnt = 0;
    longint            sums [N];
    logic signed [DW-1:0] mx [N];
    logic [N*ACCW-1:0] ey = '0;
    logic              ev = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; mcnt = 0; ev = 1'b0; ey = '0;
            for (int i = 0; i < N; i++) sums[i] = 0;
        end else begin
            ev = 1'b0;
            case (ph)
                0: if (start) begin
                    for (int i = 0; i < N; i++) begin
                        mx[i]   = $signed(vec[(N-1-i)*DW +: DW]);
                        sums[i] = 0;
                    end
                    mcnt = 0;
                    ph   = 1;
                end
                1: if (col_valid) begin
                    for (int i = 0; i < N; i++)
                        sums[i] += longint'(mx[mcnt]) * longint'($signed(col_data[(N-1-i)*DW +: DW]));
                    if (mcnt == N - 1) ph = 2;
                    mcnt++;
                end
                default: begin
                    for (int i = 0; i < N; i++) ey[(N-1-i)*ACCW +: ACCW] = sums[i][ACCW-1:0];
                    ev = 1'b1;
                    ph = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("col_ready", longint'(col_ready), longint'(ph == 1));
            cmp("busy", longint'(busy), longint'(ph != 0));
            cmp("y_valid", longint'(y_valid), longint'(ev));
            cmpv("y", y, ey);
        end
        if (col_ready) rdy_cnt++;
        if (y_valid) pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        vec   = pack_vec();
        start = 1'b1;
        tick();
        scyc  = cyc;
        start = 1'b0;
    endtask

    task automatic feed(input int ncols, input int stall_after, input int stall_len, input int mid_at);
        for (int j = 0; j < ncols; j++) begin
            col_valid = 1'b1;
            col_data  = pack_col(j);
            if (j == mid_at) begin
                start = 1'b1;
                vec   = {N{16'h0003}};
            end
            tick();
            start = 1'b0;
            if (j == stall_after - 1) begin
                col_valid = 1'b0;
                col_data  = {N{16'h5A5A}};
                repeat (stall_len) tick();
            end
        end
        col_valid = 1'b0;
    endtask

    task automatic wait_y(input string nm, input longint exp_dly);
        longint dly;
        dly = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (y_valid) begin
                dly = cyc - scyc;
                break;
            end
        end
        if (dly < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: y_valid never seen, required after %0d cycles", nm, exp_dly);
        end else begin
            cmp(nm, dly, exp_dly);
        end
    endtask

    task automatic rand_mat();
        for (int j = 0; j < N; j++) begin
            tv[j] = 16'($urandom);
            for (int i = 0; i < N; i++) mat[j][i] = 16'($urandom);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        cmp("reset y_valid", longint'(y_valid), 0);
        cmp("reset busy", longint'(busy), 0);
        cmp("reset col_ready", longint'(col_ready), 0);
        cmpv("reset y", y, '0);
        #1;
        rst = 1'b0;
        tick();

        // 1 Identity, col_valid already high in the start cycle
        for (int j = 0; j < N; j++) begin
            tv[j] = 16'(j + 1);
            for (int i = 0; i < N; i++) mat[j][i] = (i == j) ? 16'sd1 : 16'sd0;
        end
        rdy_cnt = 0; pulses = 0;
        col_valid = 1'b1;
        col_data  = pack_col(0);
        do_start();
        feed(N, -1, 0, -1);
        wait_y("t1 latency", 17);
        for (int i = 0; i < N; i++) cmp("t1 y elem", y_elem(i), longint'(i + 1));
        repeat (4) tick();
        cmp("t1 pulse count", pulses, 1);
        cmp("t1 col_ready cycles", rdy_cnt, 16);

        // 2 Extremes
        for (int j = 0; j < N; j++) begin
            tv[j] = 16'sh8000;
            for (int i = 0; i < N; i++) mat[j][i] = 16'sh8000;
        end
        do_start();
        feed(N, -1, 0, -1);
        wait_y("t2a latency", 17);
        for (int i = 0; i < N; i++) cmp("t2a y elem", y_elem(i), 64'sd17179869184);
        tick();
        for (int j = 0; j < N; j++) tv[j] = 16'sh7FFF;
        do_start();
        feed(N, -1, 0, -1);
        wait_y("t2b latency", 17);
        for (int i = 0; i < N; i++) cmp("t2b y elem", y_elem(i), -64'sd17179344896);
        tick();

        // 3 Stall after the 5th column
        rand_mat();
        do_start();
        feed(N, 5, 3, -1);
        wait_y("t3 latency", 20);
        tick();

        // 4 col_valid in IDLE, start mid-ACCUM with another vector
        for (int j = 0; j < N; j++) begin
            tv[j] = 16'(100 - j);
            for (int i = 0; i < N; i++) mat[j][i] = (i == j) ? 16'sd1 : 16'sd0;
        end
        col_valid = 1'b1;
        col_data  = {N{16'h7001}};
        repeat (3) tick();
        do_start();
        feed(N, -1, 0, 7);
        wait_y("t4 latency", 17);
        for (int i = 0; i < N; i++) cmp("t4 y elem", y_elem(i), longint'(100 - i));
        tick();

        // 5 Reset after 8 accepts, then a full operation
        rand_mat();
        do_start();
        feed(8, -1, 0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        cmpv("t5 y after reset", y, '0);
        cmp("t5 y_valid after reset", longint'(y_valid), 0);
        cmp("t5 busy after reset", longint'(busy), 0);
        #1;
        rand_mat();
        do_start();
        feed(N, -1, 0, -1);
        wait_y("t5 latency", 17);

        // 6 Back-to-back: next start issued in the y_valid cycle
        rand_mat();
        do_start();
        feed(N, -1, 0, -1);
        wait_y("t6a latency", 17);
        rand_mat();
        do_start();
        feed(N, 2, 1, -1);
        wait_y("t6b latency", 18);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
